// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear request/ready, packed read ports and packed write ports.
interface regfile_mp_if #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned NUM_WR_PORTS = 1
);
   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   logic                                 clear_req_i;
   logic                                 ready_o;
   logic [NUM_RD_PORTS*ADDR_W-1:0]       rd_addr_i;
   logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data_o;
   logic [NUM_WR_PORTS-1:0]              wr_en_i;
   logic [NUM_WR_PORTS*ADDR_W-1:0]       wr_addr_i;
   logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wr_data_i;

   modport master (
      output clear_req_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
      input  ready_o, rd_data_o
   );

   modport slave (
      input  clear_req_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
      output ready_o, rd_data_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hard-wired to zero and a clear sequencer after reset/flush.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned NUM_WR_PORTS = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);
   localparam int unsigned ADDR_W = $clog2(NUM_REGS);
   localparam int unsigned DW     = DATA_WIDTH;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
   logic                ready_q, ready_d;
   logic [DW-1:0]       regs_q [NUM_REGS];
   logic [DW-1:0]       regs_d [NUM_REGS];
   logic [NUM_RD_PORTS*DW-1:0] rd_data_c;

   // Clear walks indices 1..NUM_REGS-1 and stops there; a flush is only taken in IDLE.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == ST_CLEAR) begin
         if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
            state_d = ST_IDLE;
         end else begin
            clr_idx_d = clr_idx_q + ADDR_W'(1);
         end
      end else if (bus.clear_req_i) begin
         state_d   = ST_CLEAR;
         clr_idx_d = ADDR_W'(1);
      end
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= ADDR_W'(1);
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
      end
   end

   // Array update: clear step in CLEAR, otherwise port writes with the highest port applied last.
   always_comb begin
      regs_d = regs_q;
      if (state_q == ST_CLEAR) begin
         regs_d[clr_idx_q] = '0;
      end else begin
         for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if (bus.wr_en_i[w] && (bus.wr_addr_i[w*ADDR_W +: ADDR_W] != '0)) begin
               regs_d[bus.wr_addr_i[w*ADDR_W +: ADDR_W]] = bus.wr_data_i[w*DW +: DW];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         regs_q[i] <= regs_d[i];
      end
   end

   // Read ports: array lookup, optional bypass, then x0 and not-ready forcing.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DW-1:0]     rdat;
      rd_data_c = '0;
      ra        = '0;
      rdat      = '0;
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
         ra   = bus.rd_addr_i[p*ADDR_W +: ADDR_W];
         rdat = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
         for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if ((state_q == ST_IDLE) && bus.wr_en_i[w] &&
                (bus.wr_addr_i[w*ADDR_W +: ADDR_W] != '0) &&
                (bus.wr_addr_i[w*ADDR_W +: ADDR_W] == ra)) begin
               rdat = bus.wr_data_i[w*DW +: DW];
            end
         end
`endif
         if (!ready_q || (ra == '0)) begin
            rdat = '0;
         end
         rd_data_c[p*DW +: DW] = rdat;
      end
   end

   assign bus.ready_o   = ready_q;
   assign bus.rd_data_o = rd_data_c;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (32x32, 2 read / 2 write ports) against an array-level model.
module tb_regfile_mp;
   localparam int unsigned CLR_EDGES = 31;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst;

   regfile_mp_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) bus ();

   regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Drive state
   logic        d_rst;
   logic        d_clr;
   logic [1:0]  d_wen;
   logic [4:0]  d_wa [2];
   logic [31:0] d_wd [2];
   logic [4:0]  d_ra [2];

   // Reference model: visible register contents plus edges left until ready
   logic [31:0] mem [32];
   int          clr_left;

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic [4:0]  ra0, ra1;
      logic [31:0] e0, e1;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) mem[i] = '0;
      clr_left = CLR_EDGES;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] r;
      if (clr_left != 0 || a == 5'd0) return 32'h0;
      r = mem[a];
      if (BYP) begin
         for (int w = 0; w < 2; w++)
            if (d_wen[w] && d_wa[w] == a) r = d_wd[w];
      end
      return r;
   endfunction

   function automatic void model_edge();
      if (d_rst) begin
         model_reset();
      end else if (clr_left > 0) begin
         clr_left--;
      end else begin
         for (int w = 0; w < 2; w++)
            if (d_wen[w] && d_wa[w] != 5'd0) mem[d_wa[w]] = d_wd[w];
         if (d_clr) model_reset();
      end
   endfunction

   task automatic apply_check();
      rst             = d_rst;
      bus.clear_req_i = d_clr;
      bus.wr_en_i     = d_wen;
      bus.wr_addr_i   = {d_wa[1], d_wa[0]};
      bus.wr_data_i   = {d_wd[1], d_wd[0]};
      bus.rd_addr_i   = {d_ra[1], d_ra[0]};
      if (d_rst) model_reset();
      #1;
      chk("ready", 32'(bus.ready_o), 32'(clr_left == 0));
      chk("rd0", bus.rd_data_o[31:0], exp_rd(d_ra[0]));
      chk("rd1", bus.rd_data_o[63:32], exp_rd(d_ra[1]));
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      apply_check();
      clock_edge();
   endtask

   task automatic idle_drive();
      d_rst = 1'b0; d_clr = 1'b0; d_wen = 2'b00;
      d_wa[0] = '0; d_wa[1] = '0; d_wd[0] = '0; d_wd[1] = '0;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!bus.ready_o && n < 100) begin
         step();
         n++;
      end
      chk(name, 32'(n), 32'(CLR_EDGES));
   endtask

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      int n;
      idle_drive();
      d_rst = 1'b1;
      d_ra[0] = 5'd1; d_ra[1] = 5'd2;
      rst = 1'b1;

      // Reset, release, clear latency, all registers zero
      repeat (3) step();
      d_rst = 1'b0;
      wait_ready("reset_clear_latency");
      for (int i = 0; i < 16; i++) begin
         d_ra[0] = 5'(2 * i); d_ra[1] = 5'(2 * i + 1);
         apply_check();
         chk("post_reset_zero0", bus.rd_data_o[31:0], 32'h0);
         chk("post_reset_zero1", bus.rd_data_o[63:32], 32'h0);
         clock_edge();
      end

      // Directed vector table
      vecs[0] = '{wen:2'b01, wa0:5'd5, wd0:32'hDEADBEEF, wa1:5'd0, wd1:32'h0, ra0:5'd5, ra1:5'd5,
                  e0:(BYP ? 32'hDEADBEEF : 32'h0), e1:(BYP ? 32'hDEADBEEF : 32'h0)};
      vecs[1] = '{wen:2'b00, wa0:5'd0, wd0:32'h0, wa1:5'd0, wd1:32'h0, ra0:5'd5, ra1:5'd5,
                  e0:32'hDEADBEEF, e1:32'hDEADBEEF};
      vecs[2] = '{wen:2'b01, wa0:5'd0, wd0:32'hFFFFFFFF, wa1:5'd0, wd1:32'h0, ra0:5'd0, ra1:5'd5,
                  e0:32'h0, e1:32'hDEADBEEF};
      vecs[3] = '{wen:2'b00, wa0:5'd0, wd0:32'h0, wa1:5'd0, wd1:32'h0, ra0:5'd0, ra1:5'd0,
                  e0:32'h0, e1:32'h0};
      vecs[4] = '{wen:2'b11, wa0:5'd7, wd0:32'h11111111, wa1:5'd7, wd1:32'h22222222, ra0:5'd7, ra1:5'd7,
                  e0:(BYP ? 32'h22222222 : 32'h0), e1:(BYP ? 32'h22222222 : 32'h0)};
      vecs[5] = '{wen:2'b00, wa0:5'd0, wd0:32'h0, wa1:5'd0, wd1:32'h0, ra0:5'd7, ra1:5'd3,
                  e0:32'h22222222, e1:32'h0};
      vecs[6] = '{wen:2'b01, wa0:5'd3, wd0:32'hA5A5A5A5, wa1:5'd0, wd1:32'h0, ra0:5'd3, ra1:5'd7,
                  e0:(BYP ? 32'hA5A5A5A5 : 32'h0), e1:32'h22222222};
      vecs[7] = '{wen:2'b00, wa0:5'd0, wd0:32'h0, wa1:5'd0, wd1:32'h0, ra0:5'd3, ra1:5'd3,
                  e0:32'hA5A5A5A5, e1:32'hA5A5A5A5};
      for (int i = 0; i < 8; i++) begin
         d_wen = vecs[i].wen;
         d_wa[0] = vecs[i].wa0; d_wd[0] = vecs[i].wd0;
         d_wa[1] = vecs[i].wa1; d_wd[1] = vecs[i].wd1;
         d_ra[0] = vecs[i].ra0; d_ra[1] = vecs[i].ra1;
         apply_check();
         chk($sformatf("vec%0d_rd0", i), bus.rd_data_o[31:0], vecs[i].e0);
         chk($sformatf("vec%0d_rd1", i), bus.rd_data_o[63:32], vecs[i].e1);
         clock_edge();
      end

      // Flush: same-edge write committed then cleared, writes during clear dropped, re-request ignored
      idle_drive();
      d_wen = 2'b01; d_wa[0] = 5'd9; d_wd[0] = 32'h00001234;
      step();
      idle_drive();
      d_ra[0] = 5'd9; d_ra[1] = 5'd10;
      apply_check();
      chk("x9_before_clear", bus.rd_data_o[31:0], 32'h00001234);
      clock_edge();
      d_clr = 1'b1; d_wen = 2'b01; d_wa[0] = 5'd10; d_wd[0] = 32'h0000CAFE;
      step();
      n = 0;
      while (!bus.ready_o && n < 100) begin
         d_clr = (n == 14);
         d_wen = 2'b11; d_wa[0] = 5'd9; d_wd[0] = 32'hFFFFFFFF;
         d_wa[1] = 5'd10; d_wd[1] = 32'h0BADF00D;
         step();
         n++;
      end
      chk("flush_clear_latency", 32'(n), 32'(CLR_EDGES));
      idle_drive();
      apply_check();
      chk("x9_after_clear", bus.rd_data_o[31:0], 32'h0);
      chk("x10_after_clear", bus.rd_data_o[63:32], 32'h0);
      clock_edge();

      // Reset asserted at clear edge 10 restarts the sequence
      d_clr = 1'b1;
      step();
      d_clr = 1'b0;
      repeat (10) step();
      d_rst = 1'b1;
      apply_check();
      chk("ready_in_reset", 32'(bus.ready_o), 32'h0);
      clock_edge();
      d_rst = 1'b0;
      wait_ready("restart_clear_latency");

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         d_rst = ($urandom_range(0, 499) == 0);
         d_clr = ($urandom_range(0, 99) == 0);
         d_wen = 2'($urandom_range(0, 3));
         d_wa[0] = rand_addr(); d_wa[1] = rand_addr();
         d_wd[0] = $urandom; d_wd[1] = $urandom;
         d_ra[0] = rand_addr(); d_ra[1] = rand_addr();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
